// File: rtl/instruction_memory_loader.sv
// instruction_memory_loader: packs a byte stream (valid/ready) into 24-bit
// instructions, MSB first, and writes them to consecutive word addresses
// starting at 0. A load of `length` words ends with a one-cycle `done` pulse.
module instruction_memory_loader #(
  parameter int N = 24,
  parameter int A = 14
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [A:0]   length,
  input  logic [7:0]   byte_in,
  input  logic         byte_valid,
  output logic         byte_ready,
  output logic         we,
  output logic [A-1:0] waddr,
  output logic [N-1:0] wdata,
  output logic         busy,
  output logic         done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]   state_r;
  logic [1:0]   state_nxt_s;
  logic [A:0]   len_r;       // latched word count for this load
  logic [A:0]   word_cnt_r;  // words written so far (A+1 bits: never wraps)
  logic [A:0]   word_inc_s;
  logic [1:0]   byte_cnt_r;  // byte position within the current word (0..2)
  logic [N-1:0] asm_r;       // word assembly shift register
  logic [A-1:0] waddr_r;
  logic [N-1:0] wdata_r;
  logic         last_byte_s;

  assign word_inc_s  = word_cnt_r + {{A{1'b0}}, 1'b1};
  assign last_byte_s = (byte_cnt_r == 2'd2);

  // Outputs are decoded from the registered state only (no path from byte_valid).
  assign byte_ready = (state_r == S_LOAD);
  assign we         = (state_r == S_WRITE);
  assign busy       = (state_r == S_LOAD) || (state_r == S_WRITE);
  assign done       = (state_r == S_DONE);
  assign waddr      = waddr_r;
  assign wdata      = wdata_r;

  // Next-state selection for the load sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          if (length == {(A+1){1'b0}}) begin
            state_nxt_s = S_DONE;
          end else begin
            state_nxt_s = S_LOAD;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LOAD: begin
        if (byte_valid && last_byte_s) begin
          state_nxt_s = S_WRITE;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_WRITE: begin
        if (word_inc_s == len_r) begin
          state_nxt_s = S_DONE;
        end else begin
          state_nxt_s = S_LOAD;
        end
      end
      S_DONE:  state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // State, counters, byte assembly and write-port registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_IDLE;
      len_r      <= {(A+1){1'b0}};
      word_cnt_r <= {(A+1){1'b0}};
      byte_cnt_r <= 2'd0;
      asm_r      <= {N{1'b0}};
      waddr_r    <= {A{1'b0}};
      wdata_r    <= {N{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      case (state_r)
        S_IDLE: begin
          if (start) begin
            len_r      <= length;
            word_cnt_r <= {(A+1){1'b0}};
            byte_cnt_r <= 2'd0;
          end
        end
        S_LOAD: begin
          if (byte_valid) begin
            asm_r <= {asm_r[N-9:0], byte_in};
            if (last_byte_s) begin
              // Third byte: publish the finished word for the WRITE cycle.
              byte_cnt_r <= 2'd0;
              wdata_r    <= {asm_r[N-9:0], byte_in};
              waddr_r    <= word_cnt_r[A-1:0];
            end else begin
              byte_cnt_r <= byte_cnt_r + 2'd1;
            end
          end
        end
        S_WRITE: begin
          word_cnt_r <= word_inc_s;
          byte_cnt_r <= 2'd0;
        end
        default: begin
          byte_cnt_r <= byte_cnt_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_memory_loader.sv
// Self-checking bench for instruction_memory_loader: random and directed loads
// compared against a word list built from the byte stream with plain arithmetic.
module tb_instruction_memory_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [14:0] length;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        we;
  logic [13:0] waddr;
  logic [23:0] wdata;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int PB_SIZE = 3 * 16384 + 8;
  logic [7:0] pb [0:PB_SIZE-1];

  instruction_memory_loader #(.N(24), .A(14)) dut (
    .clk(clk), .rst(rst), .start(start), .length(length),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .we(we), .waddr(waddr), .wdata(wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check_val({tag, "_we"},         32'(we),         32'd0);
    check_val({tag, "_busy"},       32'(busy),       32'd0);
    check_val({tag, "_done"},       32'(done),       32'd0);
  endtask

  // One load. mode: 0 continuous valid, 1 valid every 3rd cycle, 2 random valid.
  // pat: 0 random bytes, 1 incrementing, 2 fixed 12 34 56 AB CD EF, 3 fixed 01 02 03.
  // rst_at >= 0 asserts rst once that many bytes have transferred.
  // restart_c > 0 pulses start (length 5) in that cycle of the load.
  task automatic do_load(input int len, input int mode, input int pat,
                         input int rst_at, input int restart_c, input int post);
    int idx, wr, c, budget, nbytes, k;
    bit got, vprev, rprev, v;
    logic [13:0] last_addr;
    logic [7:0] fix [0:5];
    fix[0] = 8'h12; fix[1] = 8'h34; fix[2] = 8'h56;
    fix[3] = 8'hAB; fix[4] = 8'hCD; fix[5] = 8'hEF;
    nbytes = 3 * len;
    for (int i = 0; i < PB_SIZE; i++) begin
      if (i >= nbytes + 8) break;
      case (pat)
        1: pb[i] = 8'(i);
        2: pb[i] = (i < 6) ? fix[i] : 8'($urandom);
        3: pb[i] = (i < 3) ? 8'(i + 1) : 8'($urandom);
        default: pb[i] = 8'($urandom);
      endcase
    end
    start = 1'b1; length = 15'(len); byte_valid = 1'b0; byte_in = 8'h00;
    @(negedge clk);
    start = 1'b0;
    c = 1; idx = 0; wr = 0; got = 1'b0; vprev = 1'b0; rprev = 1'b0; last_addr = 14'd0;
    budget = 16 * len + 20;
    while (!got && c < budget) begin
      if (vprev && rprev) idx++;
      if (we) begin
        k = 3 * wr;
        check_val("we_byte_ready", 32'(byte_ready), 32'd0);
        check_val("we_bytes_taken", 32'(idx), 32'(3 * (wr + 1)));
        check_val("we_beyond_len", 32'(wr < len), 32'd1);
        check_val("waddr", 32'(waddr), 32'(wr));
        check_val("wdata", 32'(wdata), (32'(pb[k]) << 16) | (32'(pb[k+1]) << 8) | 32'(pb[k+2]));
        last_addr = waddr;
        wr++;
      end
      check_val("busy", 32'(busy), 32'(!done));
      if (done) begin
        got = 1'b1;
        check_val("done_writes", 32'(wr), 32'(len));
        check_val("done_bytes", 32'(idx), 32'(nbytes));
        check_val("done_ready", 32'(byte_ready), 32'd0);
        if (mode == 0) check_val("done_latency", 32'(c), 32'(1 + 4 * len));
        if (len == 16384) check_val("last_addr", 32'(last_addr), 32'h3FFF);
      end
      if (rst_at >= 0 && idx == rst_at && !got) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; byte_valid = 1'b0; start = 1'b0;
        check_idle("rst");
        check_val("rst_waddr", 32'(waddr), 32'd0);
        check_val("rst_wdata", 32'(wdata), 32'd0);
        return;
      end
      rprev = byte_ready;
      if (restart_c == c) begin
        start = 1'b1; length = 15'd5;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0: v = 1'b1;
        1: v = (c % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      byte_valid = v;
      byte_in = pb[(idx < PB_SIZE) ? idx : 0];
      vprev = v;
      if (!got) begin
        @(negedge clk);
        c++;
      end
    end
    if (!got) check_val("done_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0; start = 1'b0;
    for (int p = 0; p < post; p++) begin
      @(negedge clk);
      check_idle("post");
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; length = 15'd0; byte_valid = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_val("reset_waddr", 32'(waddr), 32'd0);
    check_val("reset_wdata", 32'(wdata), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_load(2, 0, 2, -1, -1, 2);   // 0x123456 @0, 0xABCDEF @1, done 9 cycles after start
    do_load(1, 1, 3, -1, -1, 2);   // gapped valid, 0x010203 @0
    do_load(0, 0, 0, -1, -1, 2);   // empty load
    do_load(3, 0, 0, 5, -1, 0);    // reset after 2 bytes of word 1
    do_load(1, 0, 0, -1, -1, 2);   // fresh load after reset writes address 0
    do_load(2, 0, 0, -1, 3, 3);    // start mid-load with length 5 is ignored

    for (int r = 0; r < 20; r++) begin
      do_load($urandom_range(0, 6), $urandom_range(0, 2), 0, -1, -1, 1);  // back-to-back
    end

    do_load(16384, 0, 1, -1, -1, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/instruction_memory_loader.md
# instruction_memory_loader

Write-side counterpart of `instruction_memory_v2`. It accepts a byte stream from a host link, such as a UART receiver or a debug port, through a valid/ready handshake. It packs each group of three bytes, MSB first, into one 24-bit instruction and drives the instruction memory write port at consecutive word addresses starting from 0. The processor holds off fetching until `done` fires; a program of `length` words is then resident.

## Interface
- `N`, 24, instruction width; fixed at 3 bytes.
- `A`, 14, instruction memory address width.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a load; sampled only in IDLE.
- `length`  in  A+1  number of words to load (0..2^A); sampled in the `start` cycle.
- `byte_in`  in  8  incoming program byte.
- `byte_valid`  in  1  `byte_in` is valid.
- `byte_ready`  out  1  loader can accept a byte this cycle.
- `we`  out  1  instruction memory write enable; one-cycle pulse per word.
- `waddr`  out  A  word address of the current write.
- `wdata`  out  N  instruction to write.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse when the load completes.

## Operation
- Byte transfer rule: a byte transfers when `byte_valid && byte_ready` at a rising edge. `byte_valid` may stay high; the loader never drops or duplicates bytes.
- IDLE:
  - `byte_ready=0`, `we=0`, `busy=0`.
  - `start=1` latches `length`, clears the word counter and the byte counter (0..2), and goes to LOAD.
  - If the latched `length` is 0, go to DONE instead.
- LOAD:
  - `byte_ready=1`.
  - Each accepted byte shifts into the word assembly register: byte 0 → `[23:16]`, byte 1 → `[15:8]`, byte 2 → `[7:0]`.
  - Accepting byte 2 goes to WRITE.
- WRITE (one cycle):
  - `we=1`, `waddr` = word counter, `wdata` = assembled word, `byte_ready=0`.
  - Next: the word counter increments and the byte counter clears.
  - If the incremented count equals the latched `length`, go to DONE; else go to LOAD.
- DONE (one cycle): `done=1`, `busy=0`; next state IDLE.
- `start` outside IDLE is ignored. A change on `length` after it is latched has no effect.
- Address wrap: `length`=2^A writes addresses 0..2^A−1. The counter is A+1 bits, so there is no wrap and no write past the last address.
- Reset mid-operation:
  - Next state is IDLE and all outputs take their reset values.
  - A partially assembled word is discarded and the word counter clears.
  - A `we` that would have occurred in the reset cycle is not issued.
- Reset values: `byte_ready=0`, `we=0`, `waddr=0`, `wdata=0`, `busy=0`, `done=0`, state IDLE.

## Timing
- All outputs are registered or decoded from the registered state only. No combinational path from `byte_valid` to any output, including `byte_ready`.
- `busy` and `byte_ready` rise in the cycle after `start` is sampled.
- `we` is asserted in the cycle after the third byte of a word is accepted.
- `waddr`/`wdata` are stable while `we=1`. Outside WRITE they hold their last values.
- Peak throughput: 3 bytes per 4 cycles, because `byte_ready` is low during WRITE.
- `done` fires the cycle after the last `we`. Load of L words with continuous `byte_valid`: 1 + 4L cycles from the `start` edge to the `done` cycle.
- `length`=0: `done` in the cycle after `start`; no `we`, no byte accepted.
- Back-to-back loads: `start` may be asserted in the cycle after `done` (IDLE); it is honored.

## Test plan
- Reset, then `start` with `length`=2 and bytes 0x12,0x34,0x56,0xAB,0xCD,0xEF presented continuously:
  - `we` at address 0 with 0x123456, then at address 1 with 0xABCDEF.
  - `done` 9 cycles after `start`; `byte_ready` low during each WRITE.
- Gapped `byte_valid` (valid every 3rd cycle), `length`=1, bytes 0x01,0x02,0x03 → exactly one write of 0x010203 at address 0; no extra bytes consumed.
- `length`=0 → `done` in the cycle after `start`; `we` never asserted; `byte_ready` stays 0.
- `rst` asserted after 2 bytes of word 1 (`length`=3) → no further `we`, outputs at reset values. A new `start` with `length`=1 writes address 0 with the first 3 new bytes.
- `start` pulsed again mid-load, with `length` changed from 2 to 5 → ignored; exactly 2 writes and one `done`.
- `length`=16384 with an incrementing byte pattern → the last write is at address 0x3FFF; `done` follows; the write count is 16384.
